// File: rtl/door_code_sender.sv
// Keypad-side transmitter: pulses the lock's reset, shifts a code into it MSB first,
// then reports whether the lock granted, denied, or failed to answer in time.
module door_code_sender #(
    parameter int CODE_LEN     = 4,
    parameter int RESP_TIMEOUT = 8
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                Start,
    input  logic [CODE_LEN-1:0] Code,
    input  logic                Lock_Out,
    input  logic                Lock_Err,
    output logic                B,
    output logic                Lock_Rst,
    output logic                Busy,
    output logic                Done,
    output logic                Granted,
    output logic                Denied,
    output logic                Timeout
);

    localparam int BW = $clog2(CODE_LEN + 1);
    localparam int TW = $clog2(RESP_TIMEOUT + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(CODE_LEN);
    localparam logic [TW-1:0] TO_LAST  = TW'(RESP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SEND,
        WAIT,
        DONE
    } state_t;

    state_t              state_q;
    logic [CODE_LEN-1:0] shift_q;
    logic [BW-1:0]       bit_cnt_q;
    logic [TW-1:0]       to_cnt_q;
    logic                b_q;
    logic                lock_rst_q;
    logic                busy_q;
    logic                done_q;
    logic                granted_q;
    logic                denied_q;
    logic                timeout_q;

    // Lock_Rst resets high so the lock stays in its initial state while we are held in reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            to_cnt_q   <= '0;
            b_q        <= 1'b0;
            lock_rst_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            granted_q  <= 1'b0;
            denied_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    b_q        <= 1'b0;
                    lock_rst_q <= 1'b0;
                    busy_q     <= 1'b0;
                    if (Start) begin
                        shift_q    <= Code;
                        granted_q  <= 1'b0;
                        denied_q   <= 1'b0;
                        timeout_q  <= 1'b0;
                        lock_rst_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= CLR;
                    end
                end
                CLR: begin
                    lock_rst_q <= 1'b0;
                    b_q        <= shift_q[CODE_LEN-1];
                    shift_q    <= shift_q << 1;
                    bit_cnt_q  <= BW'(1);
                    state_q    <= SEND;
                end
                SEND: begin
                    if (bit_cnt_q == LAST_BIT) begin
                        b_q      <= 1'b0;
                        to_cnt_q <= '0;
                        state_q  <= WAIT;
                    end else begin
                        b_q       <= shift_q[CODE_LEN-1];
                        shift_q   <= shift_q << 1;
                        bit_cnt_q <= bit_cnt_q + BW'(1);
                    end
                end
                WAIT: begin
                    to_cnt_q <= to_cnt_q + TW'(1);
                    // Err outranks Out when the lock reports both.
                    if (Lock_Err) begin
                        denied_q <= 1'b1;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else if (Lock_Out) begin
                        granted_q <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else if (to_cnt_q == TO_LAST) begin
                        timeout_q <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign B        = b_q;
    assign Lock_Rst = lock_rst_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Granted  = granted_q;
    assign Denied   = denied_q;
    assign Timeout  = timeout_q;

endmodule
